// File: rtl/extensor_pkg.sv
// Shared encodings for the load extender: field sizes, justification side and pipeline states.
package extensor_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_FULL = 2'd3
    } size_e;

    typedef enum logic {
        SIDE_LSB = 1'b0,
        SIDE_MSB = 1'b1
    } side_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // Field width in bits; SZ_FULL collapses to SZ_WORD when tam is 32.
    function automatic int unsigned field_bits(size_e sz, int unsigned tam);
        case (sz)
            SZ_BYTE: field_bits = 8;
            SZ_HALF: field_bits = 16;
            SZ_WORD: field_bits = 32;
            default: field_bits = tam;
        endcase
    endfunction

endpackage

// File: rtl/extensor_load_if.sv
// Input/output valid-ready channels of the load extender.
interface extensor_load_if #(
    parameter int unsigned tamOp = 32
);
    localparam int unsigned OFF_W = $clog2(tamOp / 8);

    logic             in_valid;
    logic             in_ready;
    logic [tamOp-1:0] in_data;
    logic [OFF_W-1:0] in_off;
    logic [1:0]       in_size;
    logic             in_signed;
    logic             in_side;
    logic             out_valid;
    logic             out_ready;
    logic [tamOp-1:0] out_data;
    logic             out_err;

    modport slave (
        input  in_valid, in_data, in_off, in_size, in_signed, in_side, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

    modport master (
        output in_valid, in_data, in_off, in_size, in_signed, in_side, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/extensor_field.sv
// Combinational field select and sign/zero extend or left-justify.
// EXTENSOR_LOAD_MISALIGN_ERR_EN: flag misaligned offsets instead of aligning them down.
module extensor_field
    import extensor_pkg::*;
#(
    parameter  int unsigned tamOp = 32,
    localparam int unsigned OFF_W = $clog2(tamOp / 8)
) (
    input  logic [tamOp-1:0] data,
    input  logic [OFF_W-1:0] off,
    input  logic [1:0]       size,
    input  logic             sgn,
    input  logic             side,
    output logic [tamOp-1:0] result_c,
    output logic             err_c
);

    int unsigned      field_w;
    logic [OFF_W-1:0] lane_mask;
    logic [OFF_W-1:0] off_al;
    logic [tamOp-1:0] shifted;
    logic [tamOp-1:0] mask;
    logic [tamOp-1:0] field;
    logic [tamOp-1:0] ext;
    logic             sign_bit;

    always_comb begin
        field_w   = field_bits(size_e'(size), tamOp);
        // Offset bits below the field's natural alignment.
        lane_mask = OFF_W'(field_w / 8 - 1);
        off_al    = off & ~lane_mask;
        shifted   = data >> {off_al, 3'b000};
        mask      = {tamOp{1'b1}} >> (tamOp - field_w);
        field     = shifted & mask;
        sign_bit  = |(field & ~(mask >> 1));
        // Full width falls out naturally: zero shift and an all-ones mask.
        if (side == SIDE_MSB) begin
            ext = field << (tamOp - field_w);
        end else if (sgn && sign_bit) begin
            ext = field | ~mask;
        end else begin
            ext = field;
        end
`ifdef EXTENSOR_LOAD_MISALIGN_ERR_EN
        err_c    = |(off & lane_mask);
        result_c = err_c ? '0 : ext;
`else
        err_c    = 1'b0;
        result_c = ext;
`endif
    end

endmodule

// File: rtl/extensor_load.sv
// Registered load extender: output register plus one-entry skid, valid/ready on both sides.
// EXTENSOR_LOAD_MISALIGN_ERR_EN enables the misaligned-access flag on out_err.
module extensor_load
    import extensor_pkg::*;
#(
    parameter int unsigned tamOp = 32
) (
    input  logic            clk,
    input  logic            reset,
    extensor_load_if.slave  bus
);

    state_e           state;
    state_e           state_n;
    logic [tamOp-1:0] res_c;
    logic             res_err_c;
    logic [tamOp-1:0] out_data_q;
    logic             out_err_q;
    logic             out_valid_q;
    logic [tamOp-1:0] skid_data;
    logic             skid_err;
    logic             in_ready_q;
    logic             in_fire;
    logic             out_fire;
    logic             load_out;
    logic             load_skid;
    logic             move_skid;

    extensor_field #(.tamOp(tamOp)) u_field (
        .data     (bus.in_data),
        .off      (bus.in_off),
        .size     (bus.in_size),
        .sgn      (bus.in_signed),
        .side     (bus.in_side),
        .result_c (res_c),
        .err_c    (res_err_c)
    );

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    always_comb begin
        state_n   = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_n  = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_out = 1'b1;
                end else if (in_fire) begin
                    state_n   = TWO;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_n = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_n   = ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state       <= state_n;
            out_valid_q <= (state_n != EMPTY);
            in_ready_q  <= (state_n != TWO);
        end
    end

    // Data registers hold unless a load or skid move is requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q <= '0;
            out_err_q  <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
        end else begin
            if (load_out) begin
                out_data_q <= res_c;
                out_err_q  <= res_err_c;
            end else if (move_skid) begin
                out_data_q <= skid_data;
                out_err_q  <= skid_err;
            end
            if (load_skid) begin
                skid_data <= res_c;
                skid_err  <= res_err_c;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_extensor_load.sv
// Directed bench for extensor_load: 32- and 64-bit instances, vector table plus handshake sequences.
module tb_extensor_load;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    extensor_load_if #(.tamOp(32)) b32 ();
    extensor_load_if #(.tamOp(64)) b64 ();

    extensor_load #(.tamOp(32)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));
    extensor_load #(.tamOp(64)) u64 (.clk(clk), .reset(reset), .bus(b64.slave));

    typedef struct {
        logic        wide;
        logic [63:0] data;
        logic [2:0]  off;
        logic [1:0]  size;
        logic        sgn;
        logic        side;
        logic [63:0] exp;
        logic        err;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive32(input logic [31:0] d);
        b32.in_data   = d;
        b32.in_off    = 2'd0;
        b32.in_size   = 2'd2;
        b32.in_signed = 1'b0;
        b32.in_side   = 1'b0;
        b32.in_valid  = 1'b1;
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{1'b0, 64'h0000_0000_1234_80FF, 3'd1, 2'd0, 1'b1, 1'b0, 64'h0000_0000_FFFF_FF80, 1'b0};
        vecs[1]  = '{1'b0, 64'h0000_0000_8001_7FFF, 3'd2, 2'd1, 1'b0, 1'b0, 64'h0000_0000_0000_8001, 1'b0};
        vecs[2]  = '{1'b0, 64'h0000_0000_8001_7FFF, 3'd2, 2'd1, 1'b1, 1'b0, 64'h0000_0000_FFFF_8001, 1'b0};
        vecs[3]  = '{1'b0, 64'h0000_0000_0000_00AB, 3'd0, 2'd0, 1'b1, 1'b1, 64'h0000_0000_AB00_0000, 1'b0};
`ifdef EXTENSOR_LOAD_MISALIGN_ERR_EN
        vecs[4]  = '{1'b0, 64'h0000_0000_CAFE_BEEF, 3'd1, 2'd1, 1'b0, 1'b0, 64'h0, 1'b1};
`else
        vecs[4]  = '{1'b0, 64'h0000_0000_CAFE_BEEF, 3'd1, 2'd1, 1'b0, 1'b0, 64'h0000_0000_0000_BEEF, 1'b0};
`endif
        vecs[5]  = '{1'b0, 64'h0000_0000_DEAD_BEEF, 3'd0, 2'd2, 1'b1, 1'b1, 64'h0000_0000_DEAD_BEEF, 1'b0};
        vecs[6]  = '{1'b0, 64'h0000_0000_8000_0000, 3'd0, 2'd3, 1'b1, 1'b0, 64'h0000_0000_8000_0000, 1'b0};
        vecs[7]  = '{1'b0, 64'h0000_0000_7F12_3456, 3'd3, 2'd0, 1'b0, 1'b0, 64'h0000_0000_0000_007F, 1'b0};
        vecs[8]  = '{1'b0, 64'h0000_0000_00FE_0000, 3'd2, 2'd0, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFE, 1'b0};
        vecs[9]  = '{1'b0, 64'h0000_0000_BEEF_1234, 3'd2, 2'd1, 1'b1, 1'b1, 64'h0000_0000_BEEF_0000, 1'b0};
        vecs[10] = '{1'b0, 64'h0000_0000_FFFF_7FFF, 3'd0, 2'd1, 1'b1, 1'b0, 64'h0000_0000_0000_7FFF, 1'b0};
        vecs[11] = '{1'b1, 64'h8765_4321_0000_0000, 3'd4, 2'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_8765_4321, 1'b0};
        vecs[12] = '{1'b1, 64'h0123_4567_89AB_CDEF, 3'd0, 2'd3, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[13] = '{1'b1, 64'h8000_0000_0000_0000, 3'd7, 2'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
        vecs[14] = '{1'b1, 64'h0000_0000_CAFE_F00D, 3'd0, 2'd2, 1'b0, 1'b1, 64'hCAFE_F00D_0000_0000, 1'b0};

        reset = 1'b1;
        b32.in_valid = 1'b0; b32.in_data = '0; b32.in_off = '0; b32.in_size = '0;
        b32.in_signed = 1'b0; b32.in_side = 1'b0; b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.in_data = '0; b64.in_off = '0; b64.in_size = '0;
        b64.in_signed = 1'b0; b64.in_side = 1'b0; b64.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(b32.out_valid), 64'd0);
        check("rst_out_data",  64'(b32.out_data),  64'd0);
        check("rst_out_err",   64'(b32.out_err),   64'd0);
        check("rst_in_ready",  64'(b32.in_ready),  64'd1);
        reset = 1'b0;

        // Table: one beat at a time, result expected exactly one cycle later.
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            @(posedge clk);
            #1;
            if (v.wide) begin
                b64.in_data = v.data; b64.in_off = 3'(v.off); b64.in_size = v.size;
                b64.in_signed = v.sgn; b64.in_side = v.side; b64.in_valid = 1'b1;
                check($sformatf("vec%0d_in_ready", i), 64'(b64.in_ready), 64'd1);
            end else begin
                b32.in_data = 32'(v.data); b32.in_off = 2'(v.off); b32.in_size = v.size;
                b32.in_signed = v.sgn; b32.in_side = v.side; b32.in_valid = 1'b1;
                check($sformatf("vec%0d_in_ready", i), 64'(b32.in_ready), 64'd1);
            end
            @(posedge clk);
            #1;
            b32.in_valid = 1'b0;
            b64.in_valid = 1'b0;
            if (v.wide) begin
                check($sformatf("vec%0d_valid", i), 64'(b64.out_valid), 64'd1);
                check($sformatf("vec%0d_data", i),  b64.out_data, v.exp);
                check($sformatf("vec%0d_err", i),   64'(b64.out_err), 64'(v.err));
            end else begin
                check($sformatf("vec%0d_valid", i), 64'(b32.out_valid), 64'd1);
                check($sformatf("vec%0d_data", i),  64'(b32.out_data), v.exp);
                check($sformatf("vec%0d_err", i),   64'(b32.out_err), 64'(v.err));
            end
        end
        @(posedge clk);
        #1;
        check("drain_valid", 64'(b32.out_valid), 64'd0);

        // Backpressure: A, B fill output and skid, C stalls, then stream out in order.
        b32.out_ready = 1'b0;
        drive32(32'h1111_1111);
        @(posedge clk); #1;
        check("bp_ready_after_a", 64'(b32.in_ready), 64'd1);
        drive32(32'h2222_2222);
        @(posedge clk); #1;
        check("bp_ready_drop", 64'(b32.in_ready), 64'd0);
        check("bp_a_out", 64'(b32.out_data), 64'h1111_1111);
        drive32(32'h3333_3333);
        @(posedge clk); #1;
        check("bp_c_stall", 64'(b32.in_ready), 64'd0);
        check("bp_a_hold_valid", 64'(b32.out_valid), 64'd1);
        check("bp_a_hold_data", 64'(b32.out_data), 64'h1111_1111);
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_b_valid", 64'(b32.out_valid), 64'd1);
        check("bp_b_data", 64'(b32.out_data), 64'h2222_2222);
        check("bp_ready_back", 64'(b32.in_ready), 64'd1);
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        check("bp_c_valid", 64'(b32.out_valid), 64'd1);
        check("bp_c_data", 64'(b32.out_data), 64'h3333_3333);
        @(posedge clk); #1;
        check("bp_empty", 64'(b32.out_valid), 64'd0);

        // Reset with two beats held discards both.
        b32.out_ready = 1'b0;
        drive32(32'h4444_4444);
        @(posedge clk); #1;
        drive32(32'h5555_5555);
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        check("rst2_full_valid", 64'(b32.out_valid), 64'd1);
        check("rst2_full_ready", 64'(b32.in_ready), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst2_valid", 64'(b32.out_valid), 64'd0);
        check("rst2_data", 64'(b32.out_data), 64'd0);
        check("rst2_ready", 64'(b32.in_ready), 64'd1);
        reset = 1'b0;
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst2_stays_empty", 64'(b32.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
